alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The block SHALL have the following parameter: WIDTH, 32, operand and result width in bits (minimum 8, power of two).
REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- mod  input  4  operation select.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out  output  WIDTH  registered result.
- flags  output  4  registered {negative, zero, carry, overflow}.

Function
REQ-003 The block SHALL decode mod as follows: 0010 add, 0110 sub, 0000 and, 0001 or, 0011 xor, 0111 slt (signed), 1011 sltu (unsigned), 0100 sll, 0101 srl, 1101 sra, 1000 mul (see REQ-016).
REQ-004 Any other mod SHALL yield out=0 and flags=0100 with single-cycle latency; the block SHALL NOT hold the previous value.
REQ-005 The FSM SHALL have states IDLE, BUSY and DONE, and in_ready SHALL equal (state==IDLE).
REQ-006 A request SHALL be accepted on a rising edge with in_valid&&in_ready; a, b and mod SHALL be captured at that edge.
REQ-007 A non-mul accept SHALL transition IDLE->DONE, with out/flags registered at the accept edge, so out_valid rises 1 cycle after accept.
REQ-008 A mul accept SHALL transition IDLE->BUSY, run WIDTH shift-add iterations, then go BUSY->DONE, so out_valid rises WIDTH+1 cycles after accept.
REQ-009 In DONE, out_valid SHALL be 1 and out/flags SHALL be stable; DONE->IDLE SHALL occur on the edge where out_ready=1.
REQ-010 The block SHALL hold no request overlap: in_valid SHALL be ignored in BUSY and DONE, and there is no back-to-back accept in the DONE->IDLE cycle.
REQ-011 Add/sub SHALL be modulo 2^WIDTH; for add, carry = carry-out; for sub, carry = borrow (a<b unsigned); overflow SHALL be the signed two's-complement overflow.
REQ-012 Logic, shift, slt and mul operations SHALL set carry=0 and overflow=0; slt/sltu SHALL return 1 or 0 zero-extended.
REQ-013 The shift amount SHALL be b[log2(WIDTH)-1:0]; the upper bits of b SHALL be ignored; sra SHALL sign-fill.
REQ-014 For all operations, zero SHALL be (out==0) and negative SHALL be out[WIDTH-1].
REQ-015 Mul SHALL return the low WIDTH bits of the unsigned product.

Configuration
REQ-016 When the macro ALU_PIPE_MUL_EN is defined, mod 1000 SHALL be the multi-cycle mul and BUSY SHALL be reachable.
REQ-017 When ALU_PIPE_MUL_EN is undefined, mod 1000 SHALL behave as an undefined opcode (REQ-004), BUSY SHALL be unreachable, and the multiplier datapath SHALL be absent.

Reset
REQ-018 While rst_n=0, the block SHALL force: state=IDLE, out=0, flags=0000, out_valid=0, iteration counter=0, captured operands=0.
REQ-019 Reset assertion in any state, including mid-mul, SHALL abort the operation immediately with no partial result presented.
REQ-020 in_ready SHALL be 1 from the first clock edge after rst_n deasserts.

Verification (WIDTH=32)
REQ-021 The bench SHALL drive add with a=FFFFFFFF, b=00000001 and check: out=00000000, flags=0110, out_valid 1 cycle after accept.
REQ-022 The bench SHALL drive sub with a=80000000, b=00000001 and check: out=7FFFFFFF, flags=0001; then slt with a=FFFFFFFF, b=00000001 and check out=1, and sltu with the same operands and check out=0.
REQ-023 The bench SHALL drive sra with a=80000000, b=00000024 (shift amount 4) and check out=F8000000, flags=1000.
REQ-024 With ALU_PIPE_MUL_EN defined, the bench SHALL drive mul with a=00010000, b=00010001 and check: out=00010000, out_valid at cycle 33 after accept, in_ready=0 throughout.
REQ-025 The bench SHALL hold out_ready=0 for 5 cycles with in_valid=1 and new operands, and check: out/flags unchanged, in_ready=0, no new accept; then pulse out_ready=1 and check the new request is accepted the following cycle.
REQ-026 The bench SHALL pull rst_n low at cycle 10 of a mul and check: out_valid=0 and out=0 immediately; after release, in_ready=1 and a following add of 3+4 returns 7.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked IDLE/BUSY/DONE ALU with registered result and flags.
// Define ALU_PIPE_MUL_EN to add the WIDTH-cycle shift-add multiplier on mod 1000.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       mod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags
);
  localparam int SW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t           r_state;
  logic [WIDTH:0]   w_sum, w_dif;
  logic [WIDTH-1:0] w_res;
  logic [SW-1:0]    w_sh;
  logic             w_c, w_v;
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign w_sh      = b[SW-1:0];
  assign w_sum     = {1'b0, a} + {1'b0, b};
  // The extra top bit of the difference is the unsigned borrow.
  assign w_dif     = {1'b0, a} - {1'b0, b};
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (mod)
      4'b0010: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0110: begin
        w_res = w_dif[WIDTH-1:0];
        w_c   = w_dif[WIDTH];
        w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_dif[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0000: w_res = a & b;
      4'b0001: w_res = a | b;
      4'b0011: w_res = a ^ b;
      4'b0111: w_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'b1011: w_res = {{(WIDTH-1){1'b0}}, a < b};
      4'b0100: w_res = a << w_sh;
      4'b0101: w_res = a >> w_sh;
      4'b1101: w_res = $signed(a) >>> w_sh;
      default: w_res = '0;
    endcase
  end
`ifdef ALU_PIPE_MUL_EN
  logic [WIDTH-1:0] r_a, r_b, r_acc, w_acc;
  logic [SW-1:0]    r_cnt;
  assign w_acc = r_acc + (r_b[0] ? r_a : '0);
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      out     <= '0;
      flags   <= '0;
`ifdef ALU_PIPE_MUL_EN
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
`ifdef ALU_PIPE_MUL_EN
          if (mod == 4'b1000) begin
            r_state <= BUSY;
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            r_cnt   <= '0;
          end else
`endif
          begin
            r_state <= DONE;
            out     <= w_res;
            flags   <= {w_res[WIDTH-1], w_res == '0, w_c, w_v};
          end
        end
        BUSY: begin
`ifdef ALU_PIPE_MUL_EN
          r_acc <= w_acc;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == SW'(WIDTH - 1)) begin
            r_state <= DONE;
            out     <= w_acc;
            flags   <= {w_acc[WIDTH-1], w_acc == '0, 2'b00};
          end
`else
          r_state <= IDLE;
`endif
        end
        DONE: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and random checks of alu_pipe against an arithmetic reference model.
module tb_alu_pipe;
  logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic        in_ready, out_valid;
  logic [31:0] a = 0, b = 0, out;
  logic [3:0]  mod = 0, flags;
  int          errors = 0, checks = 0, lat;
`ifdef ALU_PIPE_MUL_EN
  localparam bit MUL = 1'b1;
`else
  localparam bit MUL = 1'b0;
`endif
  alu_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mod(mod), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .flags(flags)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic [3:0] m,
                                output logic [31:0] r, output logic [3:0] f);
    longint ux = x, uy = y;
    longint sx = longint'($signed(x)), sy = longint'($signed(y));
    longint t;
    int     sh = int'(y % 32);
    logic   c = 1'b0, v = 1'b0;
    r = 32'h0;
    case (m)
      4'b0010: begin
        r = 32'(ux + uy);
        c = ((ux + uy) >> 32) != 0;
        t = sx + sy;
        v = t != longint'($signed(t[31:0]));
      end
      4'b0110: begin
        r = 32'(ux - uy);
        c = x < y;
        t = sx - sy;
        v = t != longint'($signed(t[31:0]));
      end
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0011: r = x ^ y;
      4'b0111: r = (sx < sy) ? 32'd1 : 32'd0;
      4'b1011: r = (x < y) ? 32'd1 : 32'd0;
      4'b0100: r = x << sh;
      4'b0101: r = x >> sh;
      4'b1101: r = 32'(sx >>> sh);
      4'b1000: r = MUL ? 32'(ux * uy) : 32'h0;
      default: r = 32'h0;
    endcase
    f = {r[31], r == 32'h0, c, v};
  endfunction
  task automatic run(input logic [31:0] ta, input logic [31:0] tb, input logic [3:0] tm, output int l);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before", in_ready, 1);
    a = ta; b = tb; mod = tm; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    l = 0;
    do begin
      @(negedge clk);
      l++;
      if (!out_valid) chk("busy_ready", in_ready, 0);
    end while (!out_valid && l < 100);
    chk("valid_seen", out_valid, 1);
  endtask
  task automatic release_out;
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    int unsigned ops[11] = '{2, 6, 0, 1, 3, 7, 11, 4, 5, 13, 8};
    logic [31:0] ra, rb, er;
    logic [3:0]  rm, ef;
    #12;
    chk("rst_out", out, 0);
    chk("rst_flags", flags, 0);
    chk("rst_valid", out_valid, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1 chk("ready_after_rst", in_ready, 1);
    run(32'hFFFFFFFF, 32'h1, 4'b0010, lat);
    chk("add_out", out, 32'h0);
    chk("add_flags", flags, 4'b0110);
    chk("add_lat", lat, 1);
    release_out();
    run(32'h80000000, 32'h1, 4'b0110, lat);
    chk("sub_out", out, 32'h7FFFFFFF);
    chk("sub_flags", flags, 4'b0001);
    release_out();
    run(32'hFFFFFFFF, 32'h1, 4'b0111, lat);
    chk("slt_out", out, 32'h1);
    release_out();
    run(32'hFFFFFFFF, 32'h1, 4'b1011, lat);
    chk("sltu_out", out, 32'h0);
    release_out();
    run(32'h80000000, 32'h24, 4'b1101, lat);
    chk("sra_out", out, 32'hF8000000);
    chk("sra_flags", flags, 4'b1000);
    release_out();
    run(32'h1234, 32'h5678, 4'b1110, lat);
    chk("undef_out", out, 32'h0);
    chk("undef_flags", flags, 4'b0100);
    chk("undef_lat", lat, 1);
    release_out();
    run(32'h00010000, 32'h00010001, 4'b1000, lat);
    chk("mul_out", out, MUL ? 32'h00010000 : 32'h0);
    chk("mul_flags", flags, MUL ? 4'b0000 : 4'b0100);
    chk("mul_lat", lat, MUL ? 33 : 1);
    release_out();
    for (int i = 0; i < 40; i++) begin
      ra = pick();
      rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : pick();
      rm = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'(ops[$urandom_range(0, 10)]);
      model(ra, rb, rm, er, ef);
      run(ra, rb, rm, lat);
      chk("rnd_out", out, er);
      chk("rnd_flags", flags, ef);
      chk("rnd_lat", lat, (MUL && rm == 4'b1000) ? 33 : 1);
      release_out();
    end
    run(32'h5, 32'h9, 4'b0010, lat);
    a = 32'h11; b = 32'h22; mod = 4'b0010; in_valid = 1;
    repeat (5) begin
      @(negedge clk);
      chk("hold_out", out, 32'hE);
      chk("hold_flags", flags, 4'b0000);
      chk("hold_ready", in_ready, 0);
      chk("hold_valid", out_valid, 1);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("drain_valid", out_valid, 0);
    chk("drain_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
    chk("next_valid", out_valid, 1);
    chk("next_out", out, 32'h33);
    release_out();
    @(negedge clk);
`ifdef ALU_PIPE_MUL_EN
    a = 32'h3; b = 32'h5; mod = 4'b1000; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (9) @(posedge clk);
`else
    a = 32'h5; b = 32'h6; mod = 4'b0010; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
`endif
    #1 rst_n = 0;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_out", out, 32'h0);
    chk("abort_flags", flags, 4'b0000);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1 chk("abort_ready", in_ready, 1);
    run(32'h3, 32'h4, 4'b0010, lat);
    chk("post_rst_out", out, 32'h7);
    release_out();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
